ddin: RTL and testbench

MII receive deserializer for the Ethernet controller in 10 Mb/s and 100 Mb/s modes. It samples the PHY's 4-bit receive nibbles and strips the preamble and SFD. It assembles data bytes low nibble first, and reports per-frame length and error status to the receive buffer logic. It is the receive-side counterpart of the nibble transmit path.

---
 rtl/ddin.sv | 191 +++++++++++++++++++
 tb/tb_ddin.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddin.sv
// ddin - MII receive deserializer (10/100 Mb/s).
//
// Samples 4-bit receive nibbles from the PHY, strips the 0x5 preamble and the
// 0xD start-of-frame delimiter, assembles data bytes low nibble first, and
// reports the frame length and error status at end of frame.
//
// Parameters:
//   MAXLEN  maximum accepted frame length in bytes (<= 2047)
//   MINPRE  minimum number of 0x5 nibbles required before the 0xD SFD
//
// Ports:
//   rxclk_i  in   1   PHY receive clock; all state changes on its rising edge
//   rst_n    in   1   asynchronous active-low reset
//   rxdv_i   in   1   PHY receive data valid
//   rxer_i   in   1   PHY receive error
//   dat_i    in   4   PHY receive nibble
//   dat_o    out  8   assembled byte, valid while rxen_o=1
//   rxen_o   out  1   one-cycle byte strobe
//   sof_o    out  1   marks the first byte after the SFD (with rxen_o)
//   eof_o    out  1   one-cycle end-of-frame strobe
//   err_o    out  1   frame error, valid only while eof_o=1, otherwise 0
//   len_o    out  11  frame byte count, updated at eof_o and held afterwards
module ddin #(
    parameter int MAXLEN = 1518,
    parameter int MINPRE = 1
) (
    input  logic        rxclk_i,
    input  logic        rst_n,
    input  logic        rxdv_i,
    input  logic        rxer_i,
    input  logic [3:0]  dat_i,
    output logic [7:0]  dat_o,
    output logic        rxen_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        err_o,
    output logic [10:0] len_o
);

    // Preamble counter only needs to reach MINPRE; it saturates at all-ones.
    localparam int PCW = (MINPRE < 1) ? 1 : $clog2(MINPRE + 1);

    localparam logic [3:0]  NIB_PRE = 4'h5;
    localparam logic [3:0]  NIB_SFD = 4'hD;
    localparam logic [10:0] LEN_MAX = 11'(MAXLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       lo_reg, lo_next;
    logic             phase_reg, phase_next;
    logic [PCW-1:0]   pre_cnt_reg, pre_cnt_next;
    logic [10:0]      len_reg, len_next;
    logic             err_flag_reg, err_flag_next;

    logic [7:0]       dat_reg, dat_next;
    logic             rxen_reg, rxen_next;
    logic             sof_reg, sof_next;
    logic             eof_reg, eof_next;
    logic             err_reg, err_next;
    logic [10:0]      len_o_reg, len_o_next;

    always_ff @(posedge rxclk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            lo_reg       <= '0;
            phase_reg    <= 1'b0;
            pre_cnt_reg  <= '0;
            len_reg      <= '0;
            err_flag_reg <= 1'b0;
            dat_reg      <= '0;
            rxen_reg     <= 1'b0;
            sof_reg      <= 1'b0;
            eof_reg      <= 1'b0;
            err_reg      <= 1'b0;
            len_o_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            lo_reg       <= lo_next;
            phase_reg    <= phase_next;
            pre_cnt_reg  <= pre_cnt_next;
            len_reg      <= len_next;
            err_flag_reg <= err_flag_next;
            dat_reg      <= dat_next;
            rxen_reg     <= rxen_next;
            sof_reg      <= sof_next;
            eof_reg      <= eof_next;
            err_reg      <= err_next;
            len_o_reg    <= len_o_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lo_next       = lo_reg;
        phase_next    = phase_reg;
        pre_cnt_next  = pre_cnt_reg;
        len_next      = len_reg;
        err_flag_next = err_flag_reg;
        dat_next      = dat_reg;
        rxen_next     = 1'b0;
        sof_next      = 1'b0;
        eof_next      = 1'b0;
        err_next      = 1'b0;
        len_o_next    = len_o_reg;

        unique case (state_reg)
            IDLE: begin
                if (rxdv_i) begin
                    if (dat_i == NIB_PRE && !rxer_i) begin
                        state_next   = PRE;
                        pre_cnt_next = PCW'(1);
                    end else begin
                        state_next = DROP;
                    end
                end
            end

            PRE: begin
                if (!rxdv_i) begin
                    // Carrier dropped before the SFD: no frame, so no eof.
                    state_next = IDLE;
                end else if (rxer_i) begin
                    state_next = DROP;
                end else if (dat_i == NIB_PRE) begin
                    if (pre_cnt_reg != '1) begin
                        pre_cnt_next = pre_cnt_reg + PCW'(1);
                    end
                end else if (dat_i == NIB_SFD && int'(pre_cnt_reg) >= MINPRE) begin
                    state_next    = DATA;
                    phase_next    = 1'b0;
                    len_next      = '0;
                    err_flag_next = 1'b0;
                end else begin
                    state_next = DROP;
                end
            end

            DATA: begin
                if (rxdv_i) begin
                    // An rxer nibble is still assembled; the frame is just flagged.
                    if (rxer_i) begin
                        err_flag_next = 1'b1;
                    end
                    if (!phase_reg) begin
                        lo_next    = dat_i;
                        phase_next = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        if (len_reg < LEN_MAX) begin
                            dat_next  = {dat_i, lo_reg};
                            rxen_next = 1'b1;
                            sof_next  = (len_reg == 11'd0);
                            len_next  = len_reg + 11'd1;
                        end else begin
                            // Oversize: discard the byte, keep len pinned at MAXLEN.
                            err_flag_next = 1'b1;
                        end
                    end
                end else begin
                    // End of frame; a dangling low nibble or an empty frame is an error.
                    eof_next   = 1'b1;
                    len_o_next = len_reg;
                    err_next   = err_flag_reg | phase_reg | (len_reg == 11'd0);
                    state_next = IDLE;
                end
            end

            DROP: begin
                if (!rxdv_i) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign dat_o  = dat_reg;
    assign rxen_o = rxen_reg;
    assign sof_o  = sof_reg;
    assign eof_o  = eof_reg;
    assign err_o  = err_reg;
    assign len_o  = len_o_reg;

endmodule

// File: tb/tb_ddin.sv
module tb_ddin;

    logic        clk;
    logic        rst_n;
    logic        rxdv;
    logic        rxer;
    logic [3:0]  dat;

    logic [7:0]  dat_o,  dat4_o;
    logic        rxen_o, rxen4_o;
    logic        sof_o,  sof4_o;
    logic        eof_o,  eof4_o;
    logic        err_o,  err4_o;
    logic [10:0] len_o,  len4_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ddin u_dut (
        .rxclk_i (clk),
        .rst_n   (rst_n),
        .rxdv_i  (rxdv),
        .rxer_i  (rxer),
        .dat_i   (dat),
        .dat_o   (dat_o),
        .rxen_o  (rxen_o),
        .sof_o   (sof_o),
        .eof_o   (eof_o),
        .err_o   (err_o),
        .len_o   (len_o)
    );

    // Second instance with a tiny MAXLEN for the overflow case; shares inputs.
    ddin #(.MAXLEN(4), .MINPRE(1)) u_dut4 (
        .rxclk_i (clk),
        .rst_n   (rst_n),
        .rxdv_i  (rxdv),
        .rxer_i  (rxer),
        .dat_i   (dat),
        .dat_o   (dat4_o),
        .rxen_o  (rxen4_o),
        .sof_o   (sof4_o),
        .eof_o   (eof4_o),
        .err_o   (err4_o),
        .len_o   (len4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         c;
    } bev_t;

    typedef struct {
        logic [10:0] len;
        logic        err;
        int          c;
    } eev_t;

    bev_t bq[$];
    eev_t eq[$];
    int   b4_cnt = 0;
    eev_t eq4[$];
    int   overlap_cnt = 0;
    int   back2back_cnt = 0;
    logic rxen_prev = 1'b0;

    // Event collector, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (rxen_o) bq.push_back('{d: dat_o, s: sof_o, c: cyc});
        if (eof_o)  eq.push_back('{len: len_o, err: err_o, c: cyc});
        if (rxen4_o) b4_cnt++;
        if (eof4_o) eq4.push_back('{len: len4_o, err: err4_o, c: cyc});
        if (rxen_o && eof_o) overlap_cnt++;
        if (rxen_o && rxen_prev) back2back_cnt++;
        rxen_prev = rxen_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bdat(input int i);
        if (i < bq.size()) return {23'd0, bq[i].s, bq[i].d};
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] bcyc(input int i);
        if (i < bq.size()) return bq[i].c;
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] estat(input int i);
        if (i < eq.size()) return {20'd0, eq[i].err, eq[i].len};
        return 32'hDEAD;
    endfunction

    task automatic clear_q();
        bq.delete();
        eq.delete();
        eq4.delete();
        b4_cnt = 0;
    endtask

    task automatic nib(input logic dv, input logic er, input logic [3:0] d);
        @(negedge clk);
        rxdv = dv;
        rxer = er;
        dat  = d;
        $display("drive dv=%0d er=%0d nib=%h", dv, er, d);
    endtask

    task automatic idle(input int n);
        repeat (n) nib(1'b0, 1'b0, 4'h0);
    endtask

    task automatic preamble(input int n);
        repeat (n) nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'hD);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic er);
        nib(1'b1, er, b[3:0]);
        nib(1'b1, er, b[7:4]);
    endtask

    task automatic good_frame();
        preamble(15);
        send_byte(8'h01, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hFF, 1'b0);
    endtask

    int low_edge;

    initial begin
        rst_n = 1'b0;
        rxdv  = 1'b0;
        rxer  = 1'b0;
        dat   = 4'h0;

        // Reset state.
        #12;
        chk("rst_dat",  {24'd0, dat_o}, 32'h00);
        chk("rst_strb", {29'd0, rxen_o, sof_o, eof_o}, 32'h0);
        chk("rst_err",  {31'd0, err_o}, 32'h0);
        chk("rst_len",  {21'd0, len_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Good frame: bytes 01 (sof), A5, FF spaced 2 cycles; eof one cycle after rxdv falls.
        clear_q();
        good_frame();
        nib(1'b0, 1'b0, 4'h0);
        low_edge = cyc + 1;
        idle(3);
        chk("good_nbytes", bq.size(), 3);
        chk("good_b0", bdat(0), 32'h101);
        chk("good_b1", bdat(1), 32'h0A5);
        chk("good_b2", bdat(2), 32'h0FF);
        chk("good_b0_cyc", bcyc(0), low_edge - 5);
        chk("good_b1_cyc", bcyc(1), low_edge - 3);
        chk("good_b2_cyc", bcyc(2), low_edge - 1);
        chk("good_neof", eq.size(), 1);
        chk("good_eof", estat(0), {20'd0, 1'b0, 11'd3});
        chk("good_eof_cyc", (eq.size() > 0) ? eq[0].c : 32'hDEAD, low_edge);
        chk("good_len_hold", {21'd0, len_o}, 32'd3);
        chk("good_err_idle", {31'd0, err_o}, 32'd0);

        // Odd nibble count.
        clear_q();
        good_frame();
        nib(1'b1, 1'b0, 4'h7);
        idle(3);
        chk("odd_nbytes", bq.size(), 3);
        chk("odd_eof", estat(0), {20'd0, 1'b1, 11'd3});

        // rxer during the A5 byte: all bytes delivered, frame flagged.
        clear_q();
        preamble(15);
        send_byte(8'h01, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'hFF, 1'b0);
        idle(3);
        chk("rxer_nbytes", bq.size(), 3);
        chk("rxer_b1", bdat(1), 32'h0A5);
        chk("rxer_eof", estat(0), {20'd0, 1'b1, 11'd3});

        // Bad preamble: 5,5,3 then data -> nothing; next good frame received.
        clear_q();
        nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'h3);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        idle(3);
        chk("badpre_nbytes", bq.size(), 0);
        chk("badpre_neof", eq.size(), 0);
        good_frame();
        idle(3);
        chk("badpre_next_nbytes", bq.size(), 3);
        chk("badpre_next_eof", estat(0), {20'd0, 1'b0, 11'd3});

        // Length overflow: 6 bytes into MAXLEN=4 instance.
        clear_q();
        preamble(15);
        for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11), 1'b0);
        idle(3);
        chk("ovf4_nbytes", b4_cnt, 4);
        chk("ovf4_neof", eq4.size(), 1);
        chk("ovf4_eof", (eq4.size() > 0) ? {20'd0, eq4[0].err, eq4[0].len} : 32'hDEAD,
            {20'd0, 1'b1, 11'd4});
        chk("ovf_full_nbytes", bq.size(), 6);
        chk("ovf_full_b5", bdat(5), 32'h066);
        chk("ovf_full_eof", estat(0), {20'd0, 1'b0, 11'd6});

        // Back-to-back frames with a single idle cycle.
        clear_q();
        preamble(3);
        send_byte(8'h01, 1'b0);
        send_byte(8'hA5, 1'b0);
        idle(1);
        preamble(1);
        send_byte(8'h33, 1'b0);
        idle(3);
        chk("b2b_nbytes", bq.size(), 3);
        chk("b2b_b0", bdat(0), 32'h101);
        chk("b2b_b1", bdat(1), 32'h0A5);
        chk("b2b_b2", bdat(2), 32'h133);
        chk("b2b_neof", eq.size(), 2);
        chk("b2b_eof0", estat(0), {20'd0, 1'b0, 11'd2});
        chk("b2b_eof1", estat(1), {20'd0, 1'b0, 11'd1});

        // Reset mid-frame, asserted while a byte strobe is high.
        clear_q();
        preamble(4);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        rxdv = 1'b1;
        dat  = 4'hA;
        #1;
        chk("mid_rxen_pre", {31'd0, rxen_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {dat_o, rxen_o, sof_o, eof_o, err_o, len_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        send_byte(8'hBA, 1'b0);
        send_byte(8'h55, 1'b0);
        idle(3);
        chk("mid_nbytes", bq.size(), 0);
        chk("mid_neof", eq.size(), 0);

        // SFD followed immediately by rxdv low.
        clear_q();
        preamble(2);
        idle(3);
        chk("short_nbytes", bq.size(), 0);
        chk("short_eof", estat(0), {20'd0, 1'b1, 11'd0});

        // Recovery after all of the above.
        clear_q();
        good_frame();
        idle(3);
        chk("final_eof", estat(0), {20'd0, 1'b0, 11'd3});

        chk("no_rxen_eof_overlap", overlap_cnt, 0);
        chk("no_rxen_back2back", back2back_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
